// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver with majority vote, parity/framing/break flags and valid/ready holding register
module uart_rx_ovs #(
    parameter int CLK_HZ       = 27_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    RX_D_I,
    input  logic                    RX_EN_I,
    input  logic                    RX_RDY_I,
    output logic                    RX_VLD_O,
    output logic [PAYLOAD_BITS-1:0] RX_D_O,
    output logic                    RX_PERR_O,
    output logic                    RX_FERR_O,
    output logic                    RX_BREAK_O,
    output logic                    RX_OVR_O,
    output logic                    RX_BUSY_O
);
    localparam int DIV = (CLK_HZ + BIT_RATE * OVERSAMPLE / 2) / (BIT_RATE * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int H   = OVERSAMPLE / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t                  r_st, w_nxt;
    logic [1:0]              r_sync;
    logic                    r_prev, r_m0, r_m1;
    logic [DW-1:0]           r_div;
    logic [SW-1:0]           r_s;
    logic [3:0]              r_bc;
    logic [PAYLOAD_BITS-1:0] r_sh, r_d;
    logic                    r_perr, r_ferr, r_allz;
    logic                    r_vld, r_pe, r_fe, r_bk, r_ovr;
    logic                    w_rxs, w_tick, w_dec, w_end, w_maj, w_start, w_brk, w_done, w_load;

    assign w_rxs   = r_sync[1];
    assign w_tick  = r_div == DW'(DIV - 1);
    assign w_dec   = w_tick && r_s == SW'(H + 1);
    assign w_end   = w_tick && r_s == SW'(OVERSAMPLE - 1);
    assign w_maj   = (r_m0 & r_m1) | (r_m0 & w_rxs) | (r_m1 & w_rxs);
    assign w_start = r_st == IDLE && RX_EN_I && r_prev && !w_rxs;
    assign w_brk   = r_allz & ~w_maj;
    assign w_load  = w_done && (!r_vld || RX_RDY_I);

    assign RX_VLD_O   = r_vld;
    assign RX_D_O     = r_d;
    assign RX_PERR_O  = r_pe;
    assign RX_FERR_O  = r_fe;
    assign RX_BREAK_O = r_bk;
    assign RX_OVR_O   = r_ovr;
    assign RX_BUSY_O  = r_st != IDLE;

    // synchroniser, edge history, tick/sample counters and majority captures
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
            r_div  <= '0;
            r_s    <= '0;
            r_m0   <= 1'b1;
            r_m1   <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], RX_D_I};
            r_prev <= w_rxs;
            r_div  <= (w_start || w_tick) ? '0 : r_div + DW'(1);
            if (w_start) r_s <= '0;
            else if (w_tick) r_s <= (r_s == SW'(OVERSAMPLE - 1)) ? '0 : r_s + SW'(1);
            if (w_tick && r_s == SW'(H - 1)) r_m0 <= w_rxs;
            if (w_tick && r_s == SW'(H)) r_m1 <= w_rxs;
        end
    end

    // state register
    always_ff @(posedge CLK_I) begin
        r_st <= RST_I ? IDLE : w_nxt;
    end

    // next-state and frame-completion decode; disable aborts the frame
    always_comb begin
        w_nxt  = r_st;
        w_done = 1'b0;
        if (!RX_EN_I) w_nxt = IDLE;
        else case (r_st)
            IDLE:  if (w_start) w_nxt = START;
            START: if (w_dec && w_maj) w_nxt = IDLE;
                   else if (w_end) w_nxt = DATA;
            DATA:  if (w_end && r_bc == 4'(PAYLOAD_BITS - 1)) w_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (w_end) w_nxt = STOP;
            STOP:  if (w_dec && r_bc == 4'(STOP_BITS - 1)) begin
                       w_done = 1'b1;
                       w_nxt  = w_brk ? BRK : IDLE;
                   end
            BRK:   if (w_rxs) w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // frame datapath: bit counter, shift register, parity/framing/break accumulation
    always_ff @(posedge CLK_I) begin
        if (RST_I || w_start) begin
            r_bc   <= '0;
            r_sh   <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_allz <= 1'b1;
        end else begin
            if (r_st != w_nxt) r_bc <= '0;
            else if (w_end && (r_st == DATA || r_st == STOP)) r_bc <= r_bc + 4'd1;
            if (w_dec && r_st == DATA) r_sh <= {w_maj, r_sh[PAYLOAD_BITS-1:1]};
            if (w_dec && r_st == PAR) r_perr <= (PARITY == 1) ? (w_maj ^ (^r_sh)) : ~(w_maj ^ (^r_sh));
            if (w_dec && r_st == STOP) r_ferr <= r_ferr | ~w_maj;
            if (w_dec && (r_st == DATA || r_st == PAR || r_st == STOP)) r_allz <= r_allz & ~w_maj;
        end
    end

    // holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_vld <= 1'b0;
            r_d   <= '0;
            r_pe  <= 1'b0;
            r_fe  <= 1'b0;
            r_bk  <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_ovr <= w_done && r_vld && !RX_RDY_I;
            if (w_load) begin
                r_vld <= 1'b1;
                r_d   <= r_sh;
                r_pe  <= r_perr;
                r_fe  <= r_ferr | ~w_maj;
                r_bk  <= w_brk;
            end else if (RX_RDY_I) r_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: scoreboard bench for uart_rx_ovs (8N1 and 8E1 instances)
module tb_uart_rx_ovs;
    localparam int BT = 160;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic rx0 = 1'b1, en0 = 1'b1, rdy0 = 1'b1;
    logic rx1 = 1'b1, en1 = 1'b1, rdy1 = 1'b1;
    logic vld0, perr0, ferr0, brk0, ovr0, busy0;
    logic vld1, perr1, ferr1, brk1, ovr1, busy1;
    logic [7:0] d0, d1;

    exp_t q0[$], q1[$];
    int total = 0, bad = 0, n_ovr0 = 0, n_ovr1 = 0;
    time t_vld0 = 0, t_start = 0;
    logic pv0 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ovs #(.CLK_HZ(1_600_000), .BIT_RATE(10_000), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) dut0 (
        .CLK_I(clk), .RST_I(rst), .RX_D_I(rx0), .RX_EN_I(en0), .RX_RDY_I(rdy0),
        .RX_VLD_O(vld0), .RX_D_O(d0), .RX_PERR_O(perr0), .RX_FERR_O(ferr0),
        .RX_BREAK_O(brk0), .RX_OVR_O(ovr0), .RX_BUSY_O(busy0));

    uart_rx_ovs #(.CLK_HZ(1_600_000), .BIT_RATE(10_000), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
                  .PARITY(1), .STOP_BITS(1)) dut1 (
        .CLK_I(clk), .RST_I(rst), .RX_D_I(rx1), .RX_EN_I(en1), .RX_RDY_I(rdy1),
        .RX_VLD_O(vld1), .RX_D_O(d1), .RX_PERR_O(perr1), .RX_FERR_O(ferr1),
        .RX_BREAK_O(brk1), .RX_OVR_O(ovr1), .RX_BUSY_O(busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bit_out(input bit sel, input logic v, input int n);
        if (sel) rx1 = v;
        else rx0 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit hp, input logic pb, input logic sv);
        bit_out(sel, 1'b0, BT);
        for (int i = 0; i < 8; i++) bit_out(sel, d[i], BT);
        if (hp) bit_out(sel, pb, BT);
        bit_out(sel, sv, BT);
        bit_out(sel, 1'b1, 2 * BT);
    endtask

    // scoreboard monitor for the 8N1 instance
    always @(negedge clk) begin
        if (ovr0) n_ovr0++;
        if (vld0 && !pv0) t_vld0 = $time;
        pv0 = vld0;
        if (!rst && vld0 && rdy0) begin
            if (q0.size() == 0) chk("dut0_unexpected_word", {21'd0, brk0, ferr0, perr0, d0}, 32'hffff_ffff);
            else chk("dut0_word", {21'd0, brk0, ferr0, perr0, d0}, {21'd0, q0.pop_front()});
        end
    end

    // scoreboard monitor for the 8E1 instance
    always @(negedge clk) begin
        if (ovr1) n_ovr1++;
        if (!rst && vld1 && rdy1) begin
            if (q1.size() == 0) chk("dut1_unexpected_word", {21'd0, brk1, ferr1, perr1, d1}, 32'hffff_ffff);
            else chk("dut1_word", {21'd0, brk1, ferr1, perr1, d1}, {21'd0, q1.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("reset_out0", {vld0, d0, perr0, ferr0, brk0, ovr0, busy0}, 32'd0);
        chk("reset_out1", {vld1, d1, perr1, ferr1, brk1, ovr1, busy1}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        q0.push_back('{1'b0, 1'b0, 1'b0, 8'hA5});
        t_start = $time;
        send(0, 8'hA5, 0, 0, 1);
        chk("vld_latency_ok", {31'd0, (t_vld0 - t_start) >= 15410 && (t_vld0 - t_start) <= 15450}, 32'd1);

        q0.push_back('{1'b0, 1'b1, 1'b0, 8'h55});
        send(0, 8'h55, 0, 0, 0);
        chk("busy_after_ferr", {31'd0, busy0}, 32'd0);

        q0.push_back('{1'b1, 1'b1, 1'b0, 8'h00});
        bit_out(0, 1'b0, 12 * BT);
        bit_out(0, 1'b1, 2 * BT);
        q0.push_back('{1'b0, 1'b0, 1'b0, 8'h3C});
        send(0, 8'h3C, 0, 0, 1);

        bit_out(0, 1'b0, 40);
        bit_out(0, 1'b1, 3 * BT);
        chk("glitch_busy", {31'd0, busy0}, 32'd0);

        bit_out(0, 1'b0, 300);
        en0 = 1'b0;
        bit_out(0, 1'b0, 3);
        chk("disable_busy", {31'd0, busy0}, 32'd0);
        bit_out(0, 1'b0, 200);
        bit_out(0, 1'b1, 10 * BT);
        en0 = 1'b1;
        bit_out(0, 1'b1, BT);

        q1.push_back('{1'b0, 1'b0, 1'b1, 8'h01});
        send(1, 8'h01, 1, 0, 1);
        q1.push_back('{1'b0, 1'b0, 1'b0, 8'h01});
        send(1, 8'h01, 1, 1, 1);

        rdy0 = 1'b0;
        q0.push_back('{1'b0, 1'b0, 1'b0, 8'h11});
        send(0, 8'h11, 0, 0, 1);
        send(0, 8'h22, 0, 0, 1);
        chk("ovr_hold", {23'd0, vld0, d0}, {23'd0, 1'b1, 8'h11});
        chk("ovr_pulses", n_ovr0, 32'd1);
        rdy0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("vld_drop", {31'd0, vld0}, 32'd0);

        rdy0 = 1'b0;
        send(0, 8'h5A, 0, 0, 1);
        chk("pre_rst_hold", {23'd0, vld0, d0}, {23'd0, 1'b1, 8'h5A});
        bit_out(0, 1'b0, 400);
        chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        rx0 = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", {vld0, d0, perr0, ferr0, brk0, ovr0, busy0}, 32'd0);
        rst = 1'b0;
        rdy0 = 1'b1;
        bit_out(0, 1'b1, 12 * BT);

        chk("q0_empty", q0.size(), 32'd0);
        chk("q1_empty", q1.size(), 32'd0);
        chk("ovr_total0", n_ovr0, 32'd1);
        chk("ovr_total1", n_ovr1, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
